// File: rtl/bg_palette_fade_ctrl.sv
// Background palette brightness sequencer: scales palette RGB by a global level and
// steps that level toward black or full brightness. Optional abort via PAL_FADE_ABORT_EN.
module bg_palette_fade_ctrl #(
  parameter int unsigned FRAMES_PER_STEP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       cmd_valid,
  input  logic       cmd_dir,
  output logic       cmd_ready,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [4:0] level,
  input  logic       pix_valid_in,
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  output logic       pix_valid_out,
  output logic [3:0] red_out,
  output logic [3:0] green_out,
  output logic [3:0] blue_out
);

  typedef enum logic [1:0] {StIdle, StFading, StFinish} state_e;

  state_e     state_q, state_d;
  logic [4:0] level_q, level_d;
  logic [4:0] target_q, target_d;
  logic [7:0] cnt_q, cnt_d;
  logic [8:0] cnt_inc;
  logic       step_hit;
  logic [4:0] level_step;
  logic       abort_act;

`ifdef PAL_FADE_ABORT_EN
  assign abort_act = abort;
`else
  logic abort_unused;
  assign abort_unused = abort;
  assign abort_act    = 1'b0;
`endif

  // 9-bit sum so FRAMES_PER_STEP = 255 compares without wrapping.
  assign cnt_inc    = {1'b0, cnt_q} + 9'd1;
  assign step_hit   = (cnt_inc == 9'(FRAMES_PER_STEP));
  assign level_step = (target_q == 5'd0) ? level_q - 5'd1 : level_q + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      level_q  <= 5'd16;
      target_q <= 5'd16;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        // A frame_start coincident with acceptance is deliberately not counted.
        if (cmd_valid) begin
          target_d = cmd_dir ? 5'd0 : 5'd16;
          cnt_d    = 8'd0;
          state_d  = (target_d == level_q) ? StFinish : StFading;
        end
      end
      StFading: begin
        if (frame_start) begin
          if (step_hit) begin
            cnt_d   = 8'd0;
            level_d = level_step;
            if (level_step == target_q) state_d = StFinish;
          end else begin
            cnt_d = cnt_inc[7:0];
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (abort_act && (state_q != StIdle)) begin
      level_d = 5'd16;
      cnt_d   = 8'd0;
      state_d = StIdle;
    end
  end

  always_comb begin
    cmd_ready = (state_q == StIdle);
    busy      = (state_q == StFading) || (state_q == StFinish);
    done      = (state_q == StFinish);
  end

  assign level = level_q;

  // Pixel pipeline: stage 1 snapshots colour and level, stage 2 holds the scaled result.
  logic       s1_valid;
  logic [3:0] s1_red, s1_green, s1_blue;
  logic [4:0] s1_level;
  logic [8:0] prod_red, prod_green, prod_blue;
  logic       prod_unused;

  assign prod_red    = 9'(s1_red) * 9'(s1_level);
  assign prod_green  = 9'(s1_green) * 9'(s1_level);
  assign prod_blue   = 9'(s1_blue) * 9'(s1_level);
  // Bit 8 is always zero (max 240); low nibble is the discarded fraction.
  assign prod_unused = ^{prod_red[8], prod_red[3:0], prod_green[8], prod_green[3:0],
                         prod_blue[8], prod_blue[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_red        <= 4'd0;
      s1_green      <= 4'd0;
      s1_blue       <= 4'd0;
      s1_level      <= 5'd16;
      pix_valid_out <= 1'b0;
      red_out       <= 4'd0;
      green_out     <= 4'd0;
      blue_out      <= 4'd0;
    end else begin
      s1_valid      <= pix_valid_in;
      s1_red        <= red_in;
      s1_green      <= green_in;
      s1_blue       <= blue_in;
      s1_level      <= level_q;
      pix_valid_out <= s1_valid;
      red_out       <= prod_red[7:4];
      green_out     <= prod_green[7:4];
      blue_out      <= prod_blue[7:4];
    end
  end

endmodule

// File: tb/tb_bg_palette_fade_ctrl.sv
// Self-checking bench for bg_palette_fade_ctrl: directed sequence with randomized pixels and
// frame gaps, checked against an arithmetic model of the brightness level.
module tb_bg_palette_fade_ctrl;

  localparam int unsigned Fps = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_dir = 1'b0;
  logic       cmd_ready;
  logic       abort = 1'b0;
  logic       busy;
  logic       done;
  logic [4:0] level;
  logic       pix_valid_in = 1'b0;
  logic [3:0] red_in = 4'd0;
  logic [3:0] green_in = 4'd0;
  logic [3:0] blue_in = 4'd0;
  logic       pix_valid_out;
  logic [3:0] red_out;
  logic [3:0] green_out;
  logic [3:0] blue_out;

  bg_palette_fade_ctrl #(.FRAMES_PER_STEP(Fps)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .cmd_valid     (cmd_valid),
    .cmd_dir       (cmd_dir),
    .cmd_ready     (cmd_ready),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .level         (level),
    .pix_valid_in  (pix_valid_in),
    .red_in        (red_in),
    .green_in      (green_in),
    .blue_in       (blue_in),
    .pix_valid_out (pix_valid_out),
    .red_out       (red_out),
    .green_out     (green_out),
    .blue_out      (blue_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int done_seen = 0;

  always @(posedge clk) if (done === 1'b1) done_seen++;

  // Reference model: level is a pure function of frames counted since the command.
  int m_start = 16;
  int m_target = 16;
  int m_frames = 0;
  bit m_active = 0;
  int m_dones = 0;

  function automatic int exp_level();
    int d;
    if (!m_active) return m_start;
    d = m_frames / Fps;
    if (m_target == 0) return (m_start - d < 0) ? 0 : m_start - d;
    return (m_start + d > 16) ? 16 : m_start + d;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    int lv;
    lv = exp_level();
    pix_valid_in = 1'b1;
    red_in = r;
    green_in = g;
    blue_in = b;
    tick();
    pix_valid_in = 1'b0;
    check("pix_valid_1cyc", pix_valid_out, 0);
    tick();
    check("pix_valid_2cyc", pix_valid_out, 1);
    check("red_out", red_out, (r * lv) / 16);
    check("green_out", green_out, (g * lv) / 16);
    check("blue_out", blue_out, (b * lv) / 16);
    tick();
    check("pix_valid_drop", pix_valid_out, 0);
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (m_active) m_frames++;
    check("level", level, exp_level());
    if (m_active && exp_level() == m_target) begin
      check("done_on_reach", done, 1);
      m_dones++;
      m_start = m_target;
      m_active = 0;
      m_frames = 0;
      tick();
      check("done_single", done, 0);
      check("busy_after_done", busy, 0);
      check("ready_after_done", cmd_ready, 1);
    end else begin
      check("done_quiet", done, 0);
    end
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic issue_cmd(input logic dir, input logic with_frame);
    bit was_idle;
    was_idle = !m_active;
    check("cmd_ready_before", cmd_ready, was_idle ? 1 : 0);
    cmd_valid = 1'b1;
    cmd_dir = dir;
    frame_start = with_frame;
    tick();
    cmd_valid = 1'b0;
    frame_start = 1'b0;
    if (was_idle) begin
      m_target = dir ? 0 : 16;
      m_frames = 0;
      if (m_target == m_start) begin
        check("same_level_done", done, 1);
        check("same_level_keep", level, m_start);
        m_dones++;
        tick();
        check("same_level_done_drop", done, 0);
      end else begin
        m_active = 1;
        check("busy_on_accept", busy, 1);
        check("ready_low_on_accept", cmd_ready, 0);
        check("level_on_accept", level, exp_level());
      end
    end else begin
      check("ignored_busy", busy, 1);
      check("ignored_level", level, exp_level());
    end
  endtask

  initial begin
    int guard;
    // Reset state, checked while reset is held.
    repeat (3) @(negedge clk);
    check("rst_level", level, 16);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pvalid", pix_valid_out, 0);
    check("rst_rgb", {red_out, green_out, blue_out}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Passthrough at full brightness.
    pixel(4'hF, 4'h8, 4'h1);
    for (int i = 0; i < 4; i++) pixel(4'($urandom), 4'($urandom), 4'($urandom));

    // Fade out; the frame_start coincident with acceptance must not count.
    issue_cmd(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) frame_pulse();
    check("half_level", level, 8);
    pixel(4'hF, 4'h8, 4'h1);
    pixel(4'($urandom), 4'($urandom), 4'($urandom));
    for (int i = 0; i < 4; i++) frame_pulse();
    issue_cmd(1'b0, 1'b0);
    guard = 0;
    while (m_active && guard < 40) begin
      frame_pulse();
      guard++;
    end
    check("fade_out_end_level", level, 0);
    check("fade_out_one_done", done_seen, m_dones);
    pixel(4'hF, 4'h8, 4'h1);

    // Same-level command.
    issue_cmd(1'b1, 1'b0);
    check("same_level_dones", done_seen, m_dones);

    // Fade in to level 5, then abort.
    issue_cmd(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) frame_pulse();
    check("level5_in", level, 5);
    pixel(4'($urandom), 4'($urandom), 4'($urandom));
    abort = 1'b1;
    tick();
    abort = 1'b0;
`ifdef PAL_FADE_ABORT_EN
    m_active = 0;
    m_start = 16;
    m_frames = 0;
    check("abort_level", level, 16);
    check("abort_ready", cmd_ready, 1);
    check("abort_busy", busy, 0);
    repeat (3) tick();
    check("abort_no_done", done_seen, m_dones);
`else
    check("abort_ignored_level", level, 5);
    check("abort_ignored_busy", busy, 1);
    guard = 0;
    while (m_active && guard < 40) begin
      frame_pulse();
      guard++;
    end
    check("fade_in_end_level", level, 16);
    check("fade_in_dones", done_seen, m_dones);
`endif

    // Reset mid-fade at level 5, asserted between clock edges.
    issue_cmd(1'b1, 1'b0);
    for (int i = 0; i < 22; i++) frame_pulse();
    check("level5_out", level, 5);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_level", level, 16);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", cmd_ready, 1);
    check("async_rst_done", done, 0);
    m_active = 0;
    m_start = 16;
    m_frames = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    check("rst_no_done", done_seen, m_dones);
    pixel(4'($urandom), 4'($urandom), 4'($urandom));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bg_palette_fade_ctrl.md
# bg_palette_fade_ctrl

Brightness sequencer for the background palette output path. It takes the 12-bit RGB produced by the palette lookup for each pixel and scales it by a global brightness level. On command, it steps that level toward black (fade out) or toward full brightness (fade in), one step every `FRAMES_PER_STEP` frames. It sits between the palette lookup and the VGA colour mux, and takes frame timing from the VGA controller.

## Interface
- `FRAMES_PER_STEP`, default 4: frames per brightness step; legal range 1..255.
- `clk` input, 1 bit: pixel clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `frame_start` input, 1 bit: single-cycle pulse at the start of each frame (vertical blank).
- `cmd_valid` input, 1 bit: fade command request.
- `cmd_dir` input, 1 bit: 1 = fade out (target level 0); 0 = fade in (target level 16).
- `cmd_ready` output, 1 bit: high when a command can be accepted (FSM in IDLE).
- `abort` input, 1 bit: cancel the fade in progress; active only with `PAL_FADE_ABORT_EN`.
- `busy` output, 1 bit: high while a fade is in progress.
- `done` output, 1 bit: single-cycle pulse when the target level is reached.
- `level` output, 5 bits: current brightness, 0..16.
- `pix_valid_in` input, 1 bit: pixel RGB valid.
- `red_in`, `green_in`, `blue_in` input, 4 bits each: palette colour.
- `pix_valid_out` output, 1 bit: `pix_valid_in` delayed 2 cycles.
- `red_out`, `green_out`, `blue_out` output, 4 bits each: scaled colour.

## Operation
- FSM states: IDLE, FADING, FINISH.
- **IDLE**
  - `cmd_ready`=1.
  - When `cmd_valid`: latch `target` (0 or 16) and clear the frame counter.
  - If `target`==`level`, go to FINISH; otherwise go to FADING.
- **FADING**
  - `busy`=1, `cmd_ready`=0.
  - Each `frame_start` increments an 8-bit frame counter.
  - When the counter reaches `FRAMES_PER_STEP`:
    - clear the counter;
    - move `level` one step toward `target` (−1 for fade out, +1 for fade in);
    - if the new level equals `target`, go to FINISH.
- **FINISH**
  - Assert `done` for one cycle, then go to IDLE.
  - `busy`=1 in FINISH.
- Commands presented while not in IDLE are ignored, not queued.
- A `frame_start` in the same cycle as a command acceptance is not counted.
- `level` holds its value between fades. A fade in after a completed fade out runs from 0 up to 16.
- Scaling, per channel: `out = (in × level) >> 4`.
  - 4b × 5b gives a 9-bit product; keep bits [7:4].
  - The maximum result is 15 × 16 / 16 = 15, so there is no overflow.
  - `level` 16 passes colours through unchanged; `level` 0 gives black.
- Total fade duration is `16 × FRAMES_PER_STEP` frames.

## Timing
- Pixel pipeline, 2 stages:
  - Stage 1 registers RGB, valid, and a snapshot of `level`.
  - Stage 2 registers the scaled RGB and valid.
  - Latency from input to `*_out` and `pix_valid_out` is 2 cycles, at full throughput with no stalls.
- `level` updates on the clock edge where the `frame_start` that completes a step is sampled. Pixels entering stage 1 on the next cycle or later use the new level.
- `done` rises the cycle after `level` reaches `target`; `busy` falls the cycle after that.
- For a same-level command, `done` pulses 1 cycle after acceptance.
- Reset values:
  - state IDLE, `level`=16, frame counter 0;
  - `busy`=0, `done`=0, `cmd_ready`=1;
  - `pix_valid_out`=0, all `*_out`=0.
- Reset asserted mid-fade: all of the above take effect immediately (asynchronously), and no `done` is produced.

## Configuration
- `PAL_FADE_ABORT_EN` defined:
  - `abort` high in FADING or FINISH forces `level` to 16, clears the counter, and returns the FSM to IDLE on the next edge.
  - No `done` pulse is produced.
  - `abort` has priority over a step in the same cycle.
- `PAL_FADE_ABORT_EN` undefined: the `abort` port exists but is ignored, and fades always run to completion.

## Test plan
- Reset: hold `rst_n`=0, then release → `level`=16, `cmd_ready`=1, `busy`=0, `pix_valid_out`=0, RGB out 0.
- Passthrough: `level`=16, input RGB F/8/1 with `pix_valid_in` → output F/8/1 with `pix_valid_out` exactly 2 cycles later.
- Fade out, `FRAMES_PER_STEP`=2:
  - after 16 `frame_start` pulses, `level`=8 and input F/8/1 gives output 7/4/0;
  - after the 32nd pulse, `level`=0, `done` pulses once, and output is 0/0/0.
- Command while busy: issue fade in during a fade out → ignored; the fade out still ends at 0 with a single `done`.
- Same-level command: fade out issued when `level`=0 → `done` 1 cycle after acceptance, `level` unchanged.
- Abort/reset mid-fade at `level`=5:
  - with `PAL_FADE_ABORT_EN`, `abort` gives `level`=16, IDLE, and no `done`;
  - without the macro, `abort` has no effect;
  - `rst_n` low gives `level`=16 immediately.
